// File: rtl/shift_mix_columns.sv
// shift_mix_columns
//   Two-stage pipelined AES ShiftRows + MixColumns round stage. It sits between
//   SubBytes and AddRoundKey. The MixColumns step can be skipped for each beat,
//   which is what the final AES round needs.
//
//   Flow control: the interface is valid-only and has no backpressure. A beat
//   is transferred on every rising clk edge where valid_in = 1. The data_in and
//   last_round inputs are meaningful only in that cycle. The valid_out signal
//   is valid_in delayed by exactly two cycles. When valid_out = 0, data_out
//   holds the last result, or 0 if nothing has been produced since reset.
//
//   Ports:
//     clk        rising-edge clock
//     reset      asynchronous, active-high reset
//     valid_in   data_in / last_round are valid this cycle
//     last_round 1 = bypass MixColumns for this beat (final round)
//     data_in    128-bit state from SubBytes; byte k = data[127-8k -: 8]
//     valid_out  data_out is valid this cycle
//     data_out   transformed 128-bit state
module shift_mix_columns #(
  parameter int DATA_LEN = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_in,
  input  logic                last_round,
  input  logic [DATA_LEN-1:0] data_in,
  output logic                valid_out,
  output logic [DATA_LEN-1:0] data_out
);

  // Multiply by x in GF(2^8), reducing modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // The state is column-major: s[r][c] = byte[4c+r], and byte 0 is the MSB.
  // Row r is rotated left by r positions.
  function automatic logic [DATA_LEN-1:0] shift_rows(input logic [DATA_LEN-1:0] d);
    logic [DATA_LEN-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[DATA_LEN-1-8*(4*c+r) -: 8] = d[DATA_LEN-1-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  // Each column is multiplied by the circulant matrix {2,3,1,1}.
  // 3a is computed as xtime(a) ^ a.
  function automatic logic [DATA_LEN-1:0] mix_columns(input logic [DATA_LEN-1:0] d);
    logic [DATA_LEN-1:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = d[DATA_LEN-1-8*(4*c+0) -: 8];
      a1 = d[DATA_LEN-1-8*(4*c+1) -: 8];
      a2 = d[DATA_LEN-1-8*(4*c+2) -: 8];
      a3 = d[DATA_LEN-1-8*(4*c+3) -: 8];
      o[DATA_LEN-1-8*(4*c+0) -: 8] = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
      o[DATA_LEN-1-8*(4*c+1) -: 8] = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
      o[DATA_LEN-1-8*(4*c+2) -: 8] = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
      o[DATA_LEN-1-8*(4*c+3) -: 8] = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  logic [DATA_LEN-1:0] s1_data;
  logic                s1_valid;
  logic                s1_last;
  logic [DATA_LEN-1:0] s1_shifted;
  logic [DATA_LEN-1:0] s2_result;

  always_comb begin
    s1_shifted = shift_rows(data_in);
    s2_result  = s1_last ? s1_data : mix_columns(s1_data);
  end

  // The valid bits advance every cycle. The data and last_round registers load
  // only on a valid beat, so an idle cycle leaves the previous result in place.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_data   <= '0;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      s1_valid  <= valid_in;
      valid_out <= s1_valid;
      if (valid_in) begin
        s1_data <= s1_shifted;
        s1_last <= last_round;
      end
      if (s1_valid) begin
        data_out <= s2_result;
      end
    end
  end

endmodule

// File: tb/tb_shift_mix_columns.sv
module tb_shift_mix_columns;

  logic         clk;
  logic         reset;
  logic         valid_in;
  logic         last_round;
  logic [127:0] data_in;
  logic         valid_out;
  logic [127:0] data_out;

  int n_checks = 0;
  int n_pass   = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  shift_mix_columns #(.DATA_LEN(128)) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .last_round (last_round),
    .data_in    (data_in),
    .valid_out  (valid_out),
    .data_out   (data_out)
  );

  // Reference model: the state is held as a 4x4 byte matrix, and multiplication
  // in GF(2^8) is done with a generic shift-and-add loop.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input int b);
    logic [8:0] t;
    logic [7:0] p;
    p = 8'h00;
    t = {1'b0, a};
    for (int i = 0; i < 8; i++) begin
      if (((b >> i) & 1) == 1) p = p ^ t[7:0];
      t = {t[7:0], 1'b0};
      if (t[8]) t = t ^ 9'h11b;
    end
    return p;
  endfunction

  // MixColumns matrix entry for output row r and input row k. The matrix is
  // circulant, with first row {2,3,1,1}.
  function automatic int mc_coef(input int r, input int k);
    int d;
    d = (k - r + 4) % 4;
    return (d == 0) ? 2 : (d == 1) ? 3 : 1;
  endfunction

  function automatic logic [127:0] ref_model(input logic [127:0] d, input logic last);
    logic [7:0] st [4][4];
    logic [7:0] sh [4][4];
    logic [7:0] acc;
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = d[127-8*(4*c+r) -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        sh[r][c] = st[r][(c+r)%4];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        if (last) acc = sh[r][c];
        else begin
          acc = 8'h00;
          for (int k = 0; k < 4; k++) acc = acc ^ gf_mul(sh[k][c], mc_coef(r, k));
        end
        o[127-8*(4*c+r) -: 8] = acc;
      end
    return o;
  endfunction

  // scoreboard
  logic [127:0] exp_q[$];
  logic         prev_v;
  logic [127:0] last_out;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
  endtask

  task automatic check_data(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drives one cycle of input, then checks the output after the edge. A beat
  // that is sampled into stage 1 at an edge is visible at the output after the
  // following edge, so each check looks at the beat driven one step earlier.
  task automatic step_exp(input logic v, input logic last, input logic [127:0] d,
                          input logic [127:0] exp, input string tag);
    logic [127:0] e;
    valid_in   = v;
    last_round = last;
    data_in    = d;
    @(posedge clk);
    #1;
    check_bit({tag, "_valid"}, valid_out, prev_v);
    if (prev_v) begin
      e = exp_q.pop_front();
      check_data({tag, "_data"}, data_out, e);
      last_out = e;
    end else begin
      check_data({tag, "_hold"}, data_out, last_out);
    end
    if (v) exp_q.push_back(exp);
    prev_v = v;
  endtask

  task automatic step_rand(input logic v, input string tag);
    logic [127:0] d;
    logic         l;
    d = {$urandom, $urandom, $urandom, $urandom};
    l = 1'($urandom_range(0, 1));
    step_exp(v, l, d, ref_model(d, l), tag);
  endtask

  task automatic idle(input string tag);
    step_exp(1'b0, 1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom}, '0, tag);
  endtask

  localparam logic [127:0] V1 = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] E1 = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] V2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] E2 = 128'h0055aaff4499ee3388dd2277cc1166bb;
  localparam logic [127:0] V3 = {4{32'hdb135345}};
  localparam logic [127:0] E3 = {4{32'h8e4da1bc}};
  localparam logic [127:0] V4 = {4{32'hf20a225c}};
  localparam logic [127:0] E4 = {4{32'h9fdc589d}};

  initial begin
    reset      = 1'b1;
    valid_in   = 1'b0;
    last_round = 1'b0;
    data_in    = '0;
    prev_v     = 1'b0;
    last_out   = '0;
    repeat (2) @(posedge clk);
    #1;
    check_bit("reset_valid", valid_out, 1'b0);
    check_data("reset_data", data_out, '0);
    reset = 1'b0;

    // Directed vectors, each beat followed by idle cycles.
    step_exp(1'b1, 1'b0, V1, E1, "fips_r1");
    idle("fips_r1_out");
    idle("fips_r1_idle");
    step_exp(1'b1, 1'b1, V2, E2, "bypass");
    idle("bypass_out");
    idle("bypass_idle");
    step_exp(1'b1, 1'b0, V3, E3, "col_db");
    idle("col_db_out");
    step_exp(1'b1, 1'b0, V4, E4, "col_f2");
    idle("col_f2_out");
    idle("col_f2_idle");

    // Back-to-back beats with last_round = 0,1,0,0, followed by idle cycles.
    step_exp(1'b1, 1'b0, V1, E1, "b2b_0");
    step_exp(1'b1, 1'b1, V2, E2, "b2b_1");
    step_exp(1'b1, 1'b0, V3, E3, "b2b_2");
    step_exp(1'b1, 1'b0, V4, E4, "b2b_3");
    idle("b2b_drain");
    idle("b2b_hold0");
    idle("b2b_hold1");

    // Random traffic with bubbles and a mix of final-round and normal beats.
    for (int i = 0; i < 60; i++) step_rand(1'($urandom_range(0, 3) != 0), "rand");
    idle("rand_drain");
    idle("rand_hold");

    // Reset mid-stream: one beat is in stage 1 and a second beat is on the
    // inputs when reset is asserted between clock edges.
    step_rand(1'b1, "pre_rst_a");
    valid_in   = 1'b1;
    last_round = 1'b0;
    data_in    = V2;
    #2;
    reset = 1'b1;
    #1;
    check_bit("rst_async_valid", valid_out, 1'b0);
    check_data("rst_async_data", data_out, '0);
    exp_q.delete();
    prev_v   = 1'b0;
    last_out = '0;
    @(posedge clk);
    #1;
    check_bit("rst_held_valid", valid_out, 1'b0);
    check_data("rst_held_data", data_out, '0);
    valid_in = 1'b0;
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    idle("post_rst_0");
    idle("post_rst_1");
    step_exp(1'b1, 1'b0, V1, E1, "post_rst_beat");
    idle("post_rst_out");
    idle("post_rst_hold");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard time limit, so the run ends even if the stimulus stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed no end, expected end");
    $fatal(1, "timeout");
  end

endmodule
